// File: rtl/ranger_pkg.sv
// Shared types, 27 MHz default timing and width helper for the ultrasonic ranger family.
package ranger_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TRIG,
        ST_WAIT_RISE,
        ST_MEASURE,
        ST_HOLDOFF
    } state_e;

    localparam int DEF_TRIG_CYC    = 270;
    localparam int DEF_CYC_PER_CM  = 1566;
    localparam int DEF_MAX_CM      = 400;
    localparam int DEF_RISE_TO_CYC = 27000;
    localparam int DEF_PERIOD_CYC  = 1620000;
    localparam int DEF_DIST_W      = 9;

    // Bits needed to hold 0..value-1; never returns less than 1.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((64'd1 << r) < 64'(value)) begin
            r = r + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/ranger_sync_edge.sv
// Two-flop synchroniser for an asynchronous pin plus a delay flop for edge detection.
module ranger_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic async_i,
    output logic sync_o,
    output logic rise_o,
    output logic fall_o
);

    logic meta_q;
    logic sync_q;
    logic dly_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            dly_q  <= 1'b0;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
            dly_q  <= sync_q;
        end
    end

    assign sync_o = sync_q;
    assign rise_o = sync_q & ~dly_q;
    assign fall_o = ~sync_q & dly_q;

endmodule

// File: rtl/ultrasonic_ranger.sv
// HC-SR04-class ranging controller: trigger, echo width in whole cm, timeouts, single/continuous modes.
module ultrasonic_ranger
    import ranger_pkg::*;
#(
    parameter int TRIG_CYC    = DEF_TRIG_CYC,
    parameter int CYC_PER_CM  = DEF_CYC_PER_CM,
    parameter int MAX_CM      = DEF_MAX_CM,
    parameter int RISE_TO_CYC = DEF_RISE_TO_CYC,
    parameter int PERIOD_CYC  = DEF_PERIOD_CYC,
    parameter int DIST_W      = DEF_DIST_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              continuous,
    input  logic              ech,
    output logic              trig,
    output logic [DIST_W-1:0] dist_cm,
    output logic              dist_valid,
    output logic              timeout,
    output logic              busy
);

    localparam int CYC_MAX = (TRIG_CYC > RISE_TO_CYC) ? TRIG_CYC : RISE_TO_CYC;
    localparam int CYC_W   = clog2(CYC_MAX);
    localparam int SUB_W   = clog2(CYC_PER_CM);
    localparam int PER_W   = clog2(PERIOD_CYC);

    localparam logic [CYC_W-1:0]  TRIG_LAST = CYC_W'(TRIG_CYC - 1);
    localparam logic [CYC_W-1:0]  RISE_LAST = CYC_W'(RISE_TO_CYC - 1);
    localparam logic [SUB_W-1:0]  SUB_LAST  = SUB_W'(CYC_PER_CM - 1);
    localparam logic [PER_W-1:0]  PER_LAST  = PER_W'(PERIOD_CYC - 1);
    localparam logic [DIST_W-1:0] CM_OVF    = DIST_W'(MAX_CM + 1);

    state_e            state_q, state_d;
    logic [CYC_W-1:0]  cyc_q, cyc_d;
    logic [SUB_W-1:0]  sub_q, sub_d;
    logic [PER_W-1:0]  per_q, per_d;
    logic [DIST_W-1:0] cm_q, cm_d, cm_next;
    logic [DIST_W-1:0] dist_q, dist_d;
    logic              trig_q, trig_d;
    logic              valid_q, valid_d;
    logic              tmo_q, tmo_d;
    logic              echo_s, echo_rise, echo_fall;

    ranger_sync_edge u_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .async_i(ech),
        .sync_o (echo_s),
        .rise_o (echo_rise),
        .fall_o (echo_fall)
    );

    // The fall cycle itself is counted, so the result covers every cycle echo was high.
    assign cm_next = (sub_q == SUB_LAST) ? cm_q + DIST_W'(1) : cm_q;

    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        sub_d   = sub_q;
        cm_d    = cm_q;
        dist_d  = dist_q;
        trig_d  = 1'b0;
        valid_d = 1'b0;
        tmo_d   = 1'b0;
        per_d   = (per_q == PER_LAST) ? per_q : per_q + PER_W'(1);

        case (state_q)
            ST_IDLE: begin
                per_d = per_q;
                if (start || continuous) begin
                    state_d = ST_TRIG;
                    trig_d  = 1'b1;
                    cyc_d   = '0;
                    per_d   = '0;
                end
            end
            ST_TRIG: begin
                trig_d = 1'b1;
                if (cyc_q == TRIG_LAST) begin
                    state_d = ST_WAIT_RISE;
                    trig_d  = 1'b0;
                    cyc_d   = '0;
                end else begin
                    cyc_d = cyc_q + CYC_W'(1);
                end
            end
            ST_WAIT_RISE: begin
                if (echo_rise) begin
                    state_d = ST_MEASURE;
                    sub_d   = '0;
                    cm_d    = '0;
                end else if (cyc_q == RISE_LAST) begin
                    state_d = ST_HOLDOFF;
                    tmo_d   = 1'b1;
                end else begin
                    cyc_d = cyc_q + CYC_W'(1);
                end
            end
            ST_MEASURE: begin
                sub_d = (sub_q == SUB_LAST) ? '0 : sub_q + SUB_W'(1);
                cm_d  = cm_next;
                if (cm_next == CM_OVF) begin
                    state_d = ST_HOLDOFF;
                    tmo_d   = 1'b1;
                end else if (echo_fall) begin
                    state_d = ST_HOLDOFF;
                    dist_d  = cm_next;
                    valid_d = 1'b1;
                end
            end
            ST_HOLDOFF: begin
                // Continuous mode re-triggers on the exit edge so trigger edges stay PERIOD_CYC apart.
                if (per_q == PER_LAST && !echo_s) begin
                    if (continuous) begin
                        state_d = ST_TRIG;
                        trig_d  = 1'b1;
                        cyc_d   = '0;
                        per_d   = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cyc_q   <= '0;
            sub_q   <= '0;
            per_q   <= '0;
            cm_q    <= '0;
            dist_q  <= '0;
            trig_q  <= 1'b0;
            valid_q <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            sub_q   <= sub_d;
            per_q   <= per_d;
            cm_q    <= cm_d;
            dist_q  <= dist_d;
            trig_q  <= trig_d;
            valid_q <= valid_d;
            tmo_q   <= tmo_d;
        end
    end

    assign trig       = trig_q;
    assign dist_cm    = dist_q;
    assign dist_valid = valid_q;
    assign timeout    = tmo_q;
    assign busy       = (state_q != ST_IDLE);

endmodule
